// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// Module   : keypad_pkg
// Purpose  : Shared types, constants and helpers for the 4x4 keypad scanner.
// Revision : 1.0
// ============================================================================
package keypad_pkg;

  // Scanner states, in the order they are normally visited.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DEBOUNCE = 3'd1,
    SCAN0    = 3'd2,
    SCAN1    = 3'd3,
    SCAN2    = 3'd4,
    SCAN3    = 3'd5,
    HELD     = 3'd6,
    RELEASE  = 3'd7
  } state_t;

  // All columns driven: any pressed key shows up on the rows.
  localparam logic [3:0] COL_ALL = 4'b1111;

  // One-hot column drive for a column index.
  function automatic logic [3:0] onehot_col(input logic [1:0] idx);
    onehot_col = 4'b0001 << idx;
  endfunction

  // Index of the lowest set row bit; lowest row wins inside a column.
  function automatic logic [1:0] row_prio(input logic [3:0] row);
    if (row[0])      row_prio = 2'd0;
    else if (row[1]) row_prio = 2'd1;
    else if (row[2]) row_prio = 2'd2;
    else             row_prio = 2'd3;
  endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_row_sync.sv
`default_nettype none
// ============================================================================
// Module   : keypad_row_sync
// Purpose  : SYNC_STAGES-deep synchronizer for the asynchronous row lines.
// Revision : 1.0
// ============================================================================
module keypad_row_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_async,
  output logic [3:0] row_sync
);

  logic [SYNC_STAGES-1:0][3:0] stage;

  // Shift the raw rows through the flop chain; reset clears every rank.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stage <= '0;
    end else begin
      stage[0] <= row_async;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign row_sync = stage[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/keypad_scan_controller.sv
`default_nettype none
// ============================================================================
// Module   : keypad_scan_controller
// Purpose  : Column-scanning 4x4 hex keypad controller with press/release
//            debounce, priority resolution and a one-cycle Valid pulse.
// Revision : 1.0
// ============================================================================
module keypad_scan_controller
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SETTLE_CYCLES   = 3,
  parameter int SYNC_STAGES     = 2
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [3:0] Row,
  output logic [3:0] Col,
  output logic [3:0] Code,
  output logic       Valid,
  output logic       Key_Down
);

  localparam int CNT_MAX = (DEBOUNCE_CYCLES > SETTLE_CYCLES) ? DEBOUNCE_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  logic [3:0]       row_s;
  state_t           state, state_next;
  logic [CNT_W-1:0] count, count_next;
  logic [1:0]       scan_idx;      // column of the current SCAN state
  logic [1:0]       hold_col;      // winning column while the key is held
  logic [1:0]       hold_col_next;
  logic             capture;       // a key was found on the last dwell cycle
  logic [3:0]       col_next;
  logic [3:0]       col_r;
  logic             pend_valid;    // Valid/Code are published one cycle after capture
  logic [3:0]       pend_code;
  logic [3:0]       code_r;
  logic             valid_r;
  logic             key_down_r;

  keypad_row_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_row_sync (
    .clk      (Clock),
    .rst_n    (Reset),
    .row_async(Row),
    .row_sync (row_s)
  );

  // Column index implied by the current scan state.
  always_comb begin
    scan_idx = 2'd0;
    case (state)
      SCAN1:   scan_idx = 2'd1;
      SCAN2:   scan_idx = 2'd2;
      SCAN3:   scan_idx = 2'd3;
      default: scan_idx = 2'd0;
    endcase
  end

  // Next-state, dwell counter and column-drive decode.
  always_comb begin
    state_next    = state;
    count_next    = count + CNT_W'(1);
    capture       = 1'b0;
    hold_col_next = hold_col;
    col_next      = COL_ALL;

    unique case (state)
      IDLE: begin
        count_next = '0;
        if (row_s != 4'd0) state_next = DEBOUNCE;
      end
      DEBOUNCE: begin
        if (row_s == 4'd0)          state_next = IDLE;
        else if (count == DEB_LAST) state_next = SCAN0;
      end
      SCAN0, SCAN1, SCAN2, SCAN3: begin
        if (count == SETTLE_LAST) begin
          if (row_s != 4'd0) begin
            state_next    = HELD;
            capture       = 1'b1;
            hold_col_next = scan_idx;
          end else begin
            case (state)
              SCAN0:   state_next = SCAN1;
              SCAN1:   state_next = SCAN2;
              SCAN2:   state_next = SCAN3;
              default: state_next = IDLE;   // nothing found in the last column
            endcase
          end
        end
      end
      HELD: begin
        count_next = '0;
        if (row_s == 4'd0) state_next = RELEASE;
      end
      RELEASE: begin
        if (row_s != 4'd0)          state_next = HELD;
        else if (count == DEB_LAST) state_next = IDLE;
      end
    endcase

    if (state_next != state) count_next = '0;

    case (state_next)
      SCAN0:         col_next = onehot_col(2'd0);
      SCAN1:         col_next = onehot_col(2'd1);
      SCAN2:         col_next = onehot_col(2'd2);
      SCAN3:         col_next = onehot_col(2'd3);
      HELD, RELEASE: col_next = onehot_col(hold_col_next);
      default:       col_next = COL_ALL;
    endcase
  end

  // State, counter and column-drive registers.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state    <= IDLE;
      count    <= '0;
      hold_col <= 2'd0;
      col_r    <= COL_ALL;
    end else begin
      state    <= state_next;
      count    <= count_next;
      hold_col <= hold_col_next;
      col_r    <= col_next;
    end
  end

  // Registered output stage: code capture, Valid pulse and Key_Down level.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      pend_valid <= 1'b0;
      pend_code  <= 4'h0;
      code_r     <= 4'h0;
      valid_r    <= 1'b0;
      key_down_r <= 1'b0;
    end else begin
      pend_valid <= capture;
      if (capture) pend_code <= {row_prio(row_s), scan_idx};
      valid_r <= pend_valid;
      if (pend_valid) code_r <= pend_code;
      if (state_next == IDLE)  key_down_r <= 1'b0;
      else if (pend_valid)     key_down_r <= 1'b1;
    end
  end

  assign Col      = col_r;
  assign Code     = code_r;
  assign Valid    = valid_r;
  assign Key_Down = key_down_r;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_scan_controller
// Purpose  : Directed, self-checking bench for keypad_scan_controller with a
//            keypad row model and a code scoreboard.
// Revision : 1.0
// ============================================================================
module tb_keypad_scan_controller;

  logic        clk;
  logic        reset_n;
  logic [15:0] key;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  code;
  logic        valid;
  logic        key_down;

  int checks   = 0;
  int failures = 0;
  logic [3:0] sb[$];

  keypad_scan_controller #(
    .DEBOUNCE_CYCLES(4),
    .SETTLE_CYCLES  (3),
    .SYNC_STAGES    (2)
  ) dut (
    .Clock   (clk),
    .Reset   (reset_n),
    .Row     (row),
    .Col     (col),
    .Code    (code),
    .Valid   (valid),
    .Key_Down(key_down)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Row_Signal keypad model: a pressed key connects its column to its row.
  always_comb begin
    row = 4'b0000;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (key[r*4+c] && col[c]) row[r] = 1'b1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Scoreboard: every Valid must match the oldest outstanding expected code.
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      check("valid_expected", {31'd0, sb.size() != 0}, 32'd1);
      if (sb.size() != 0) check("code", {28'd0, code}, {28'd0, sb.pop_front()});
    end
  end

  // Count negedges until Valid rises (bounded); -1 reported on timeout.
  task automatic wait_valid(input string tag, input int exp_lat);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    while (n < 200 && !seen) begin
      @(negedge clk);
      n++;
      if (valid === 1'b1) seen = 1'b1;
    end
    check(tag, seen ? n : -1, exp_lat);
    @(negedge clk);
    check({tag, "_pulse_width"}, {31'd0, valid}, 32'd0);
  endtask

  // Count negedges until Key_Down falls (bounded); -1 reported on timeout.
  task automatic wait_keyup(input string tag, input int exp_lat);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    while (n < 200 && !seen) begin
      @(negedge clk);
      n++;
      if (key_down === 1'b0) seen = 1'b1;
    end
    check(tag, seen ? n : -1, exp_lat);
  endtask

  initial begin
    reset_n = 1'b0;
    key     = 16'h0000;
    repeat (3) @(negedge clk);
    check("rst_col", {28'd0, col}, 32'hF);
    check("rst_code", {28'd0, code}, 32'h0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_keydown", {31'd0, key_down}, 32'd0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    // 1: single key 9 (row 2, col 1)
    key = 16'h0001 << 9;
    sb.push_back(4'h9);
    wait_valid("t1_latency", 14);
    check("t1_col_held", {28'd0, col}, 32'b0010);
    check("t1_keydown", {31'd0, key_down}, 32'd1);
    repeat (24) @(negedge clk);
    check("t1_code_hold", {28'd0, code}, 32'h9);
    key = 16'h0000;
    wait_keyup("t1_release_latency", 7);
    repeat (4) @(negedge clk);

    // 2: bouncing key 5, 2 on / 1 off, never accepted
    for (int i = 0; i < 30; i++) begin
      key = ((i % 3) != 2) ? (16'h0001 << 5) : 16'h0000;
      @(negedge clk);
      check("t2_col_all", {28'd0, col}, 32'hF);
    end
    key = 16'h0000;
    repeat (6) @(negedge clk);
    check("t2_keydown", {31'd0, key_down}, 32'd0);
    check("t2_code_unchanged", {28'd0, code}, 32'h9);

    // 3: keys 4 and 12 in column 0 -> lowest row wins
    key = (16'h0001 << 4) | (16'h0001 << 12);
    sb.push_back(4'h4);
    wait_valid("t3_latency", 11);
    check("t3_col_held", {28'd0, col}, 32'b0001);
    key = 16'h0001 << 12;
    repeat (20) @(negedge clk);
    check("t3_code_hold", {28'd0, code}, 32'h4);
    check("t3_keydown", {31'd0, key_down}, 32'd1);
    key = 16'h0000;
    wait_keyup("t3_release_latency", 7);
    repeat (4) @(negedge clk);

    // 4: keys 3 (col 3) and 6 (col 2) -> lower column wins
    key = (16'h0001 << 3) | (16'h0001 << 6);
    sb.push_back(4'h6);
    wait_valid("t4_latency", 17);
    check("t4_col_held", {28'd0, col}, 32'b0100);
    check("t4_code", {28'd0, code}, 32'h6);
    key = 16'h0000;
    wait_keyup("t4_release_latency", 7);
    repeat (4) @(negedge clk);

    // 5: brief re-press during RELEASE returns to HELD without a new Valid
    key = 16'h0001 << 9;
    sb.push_back(4'h9);
    wait_valid("t5_latency", 14);
    repeat (5) @(negedge clk);
    key = 16'h0000;
    repeat (3) @(negedge clk);
    key = 16'h0001 << 9;
    @(negedge clk);
    key = 16'h0000;
    wait_keyup("t5_extended_release", 7);
    repeat (4) @(negedge clk);
    key = 16'h0001 << 9;
    sb.push_back(4'h9);
    wait_valid("t5_repress_latency", 14);
    key = 16'h0000;
    wait_keyup("t5_final_release", 7);
    repeat (4) @(negedge clk);

    // 6: reset in the middle of SCAN2 with key 10 pressed
    key = 16'h0001 << 10;
    repeat (14) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("t6_rst_col", {28'd0, col}, 32'hF);
    check("t6_rst_code", {28'd0, code}, 32'h0);
    check("t6_rst_valid", {31'd0, valid}, 32'd0);
    check("t6_rst_keydown", {31'd0, key_down}, 32'd0);
    reset_n = 1'b1;
    sb.push_back(4'hA);
    wait_valid("t6_latency", 17);
    check("t6_code", {28'd0, code}, 32'hA);
    key = 16'h0000;
    wait_keyup("t6_release_latency", 7);
    repeat (10) @(negedge clk);

    check("sb_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
